// File: rtl/sat_pkg.sv
// Shared solver types: command/response encodings, trail entry layout and literal helpers.
// A literal is {negated, variable index}; index 0 is never a valid variable.
package sat_pkg;
   localparam int SAT_NUM_VARS  = 16;
   localparam int SAT_LIT_WIDTH = 6;
   localparam int VAR_W         = SAT_LIT_WIDTH - 1;

   typedef enum logic [1:0] {
      OP_DECIDE    = 2'd0,
      OP_IMPLY     = 2'd1,
      OP_BACKTRACK = 2'd2,
      OP_CLEAR     = 2'd3
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_OK       = 3'd0,
      ST_SAT      = 3'd1,
      ST_UNSAT    = 3'd2,
      ST_CONFLICT = 3'd3,
      ST_ERR      = 3'd4
   } rsp_status_e;

   typedef struct packed {
      logic [VAR_W-1:0] var_idx;
      logic             is_dec;
   } trail_entry_t;

   function automatic logic [VAR_W-1:0] lit_var(input logic [SAT_LIT_WIDTH-1:0] lit);
      return lit[VAR_W-1:0];
   endfunction

   function automatic logic lit_neg(input logic [SAT_LIT_WIDTH-1:0] lit);
      return lit[SAT_LIT_WIDTH-1];
   endfunction

   function automatic logic [SAT_LIT_WIDTH-1:0] make_lit(input logic neg, input logic [VAR_W-1:0] v);
      return {neg, v};
   endfunction
endpackage

// File: rtl/heuristic_engine.sv
// Combinational picker: lowest-index unassigned variable, valid low when all are assigned.
// Zero latency, no flow control.
module heuristic_engine
   import sat_pkg::*;
#(
   parameter int NUM_VARS = SAT_NUM_VARS
) (
   input  logic [NUM_VARS:1] assigned,
   output logic [VAR_W-1:0]  next_var,
   output logic              valid
);
   always_comb begin
      next_var = '0;
      valid    = 1'b0;
      for (int i = NUM_VARS; i >= 1; i--) begin
         if (!assigned[i]) begin
            next_var = VAR_W'(i);
            valid    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/decision_trail_ctrl.sv
// DPLL assignment/trail sequencer: DECIDE/IMPLY/CLEAR respond the cycle after acceptance,
// BACKTRACK pops one entry per cycle and holds cmd_ready low until its response cycle ends.
module decision_trail_ctrl
   import sat_pkg::*;
#(
   parameter int NUM_VARS  = SAT_NUM_VARS,
   parameter int LIT_WIDTH = SAT_LIT_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_op,
   input  logic [LIT_WIDTH-1:0]          cmd_lit,
   output logic                          rsp_valid,
   output logic [2:0]                    rsp_status,
   output logic [LIT_WIDTH-1:0]          rsp_lit,
   output logic [NUM_VARS:1]             assigned,
   output logic [NUM_VARS:1]             values,
   output logic [$clog2(NUM_VARS+1)-1:0] level
);
   localparam int LVL_W = $clog2(NUM_VARS + 1);

   typedef enum logic {IDLE, POP} state_e;

   state_e            state_q, state_d;
   logic [NUM_VARS:1] asg_d, val_d;
   logic [LVL_W-1:0]  lvl_d, tp_q, tp_d, tr_idx;
   trail_entry_t      trail_q [NUM_VARS];
   trail_entry_t      tr_wdat, top;
   logic              tr_we, rsp_vld_d, pop_step;
   rsp_status_e       sts_d;
   logic [LIT_WIDTH-1:0] lit_d;
   logic [VAR_W-1:0]  pick_var, cmd_var;
   logic              pick_vld, cmd_neg, cmd_asg, cmd_val, top_val;
   logic [NUM_VARS:1] pick_m, cmd_m, top_m;
   cmd_op_e           op;

   function automatic logic [NUM_VARS:1] var_mask(input logic [VAR_W-1:0] v);
      var_mask = '0;
      for (int i = 1; i <= NUM_VARS; i++) var_mask[i] = (v == VAR_W'(i));
   endfunction

   heuristic_engine #(.NUM_VARS(NUM_VARS)) u_pick (
      .assigned (assigned),
      .next_var (pick_var),
      .valid    (pick_vld)
   );

   always_comb begin
      top = '0;
      for (int i = 0; i < NUM_VARS; i++) begin
         if (LVL_W'(i + 1) == tp_q) top = trail_q[i];
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign op        = cmd_op_e'(cmd_op);
   assign cmd_var   = lit_var(cmd_lit);
   assign cmd_neg   = lit_neg(cmd_lit);
   assign cmd_m     = var_mask(cmd_var);
   assign pick_m    = var_mask(pick_var);
   assign top_m     = var_mask(top.var_idx);
   assign cmd_asg   = |(assigned & cmd_m);
   assign cmd_val   = |(values & cmd_m);
   assign top_val   = |(values & top_m);

   // The acceptance edge already performs the first pop; rsp_valid in POP marks the closing cycle.
   assign pop_step = (state_q == IDLE && cmd_valid && op == OP_BACKTRACK) ||
                     (state_q == POP && !rsp_valid);

   always_comb begin
      state_d   = state_q;
      asg_d     = assigned;
      val_d     = values;
      lvl_d     = level;
      tp_d      = tp_q;
      tr_we     = 1'b0;
      tr_idx    = tp_q;
      tr_wdat   = '0;
      rsp_vld_d = 1'b0;
      sts_d     = ST_OK;
      lit_d     = '0;
      if (state_q == POP && rsp_valid) begin
         state_d = IDLE;
      end else if (pop_step) begin
         state_d = POP;
         if (tp_q == '0) begin
            asg_d     = '0;
            val_d     = '0;
            lvl_d     = '0;
            rsp_vld_d = 1'b1;
            sts_d     = ST_UNSAT;
         end else if (top.is_dec) begin
            val_d     = values ^ top_m;
            tr_we     = 1'b1;
            tr_idx    = tp_q - 1'b1;
            tr_wdat   = '{var_idx: top.var_idx, is_dec: 1'b0};
            lvl_d     = level - 1'b1;
            rsp_vld_d = 1'b1;
            lit_d     = make_lit(top_val, top.var_idx);
         end else begin
            asg_d = assigned & ~top_m;
            val_d = values & ~top_m;
            tp_d  = tp_q - 1'b1;
         end
      end else if (state_q == IDLE && cmd_valid) begin
         rsp_vld_d = 1'b1;
         case (op)
            OP_DECIDE: begin
               if (!pick_vld) begin
                  sts_d = ST_SAT;
               end else begin
                  asg_d   = assigned | pick_m;
                  val_d   = values & ~pick_m;
                  tr_we   = 1'b1;
                  tr_wdat = '{var_idx: pick_var, is_dec: 1'b1};
                  tp_d    = tp_q + 1'b1;
                  lvl_d   = level + 1'b1;
                  lit_d   = make_lit(1'b1, pick_var);
               end
            end
            OP_IMPLY: begin
               if (cmd_var == '0 || cmd_var > VAR_W'(NUM_VARS)) begin
                  sts_d = ST_ERR;
               end else if (!cmd_asg) begin
                  asg_d   = assigned | cmd_m;
                  val_d   = cmd_neg ? (values & ~cmd_m) : (values | cmd_m);
                  tr_we   = 1'b1;
                  tr_wdat = '{var_idx: cmd_var, is_dec: 1'b0};
                  tp_d    = tp_q + 1'b1;
                  lit_d   = cmd_lit;
               end else if (cmd_val == !cmd_neg) begin
                  sts_d = ST_OK;
               end else begin
                  sts_d = ST_CONFLICT;
                  lit_d = cmd_lit;
               end
            end
            OP_CLEAR: begin
               asg_d = '0;
               val_d = '0;
               tp_d  = '0;
               lvl_d = '0;
            end
            default: rsp_vld_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         assigned   <= '0;
         values     <= '0;
         level      <= '0;
         tp_q       <= '0;
         rsp_valid  <= 1'b0;
         rsp_status <= '0;
         rsp_lit    <= '0;
         for (int i = 0; i < NUM_VARS; i++) trail_q[i] <= '0;
      end else begin
         assigned   <= asg_d;
         values     <= val_d;
         level      <= lvl_d;
         tp_q       <= tp_d;
         rsp_valid  <= rsp_vld_d;
         rsp_status <= sts_d;
         rsp_lit    <= lit_d;
         for (int i = 0; i < NUM_VARS; i++) begin
            if (tr_we && tr_idx == LVL_W'(i)) trail_q[i] <= tr_wdat;
         end
      end
   end
endmodule
